// File: rtl/img_row_packer_pkg.sv
// Shared constants, FSM state type and slot placement helper for the row packer.
// Slot order is selected by IMG_PACK_MSB_FIRST_EN (defined: first word in the MSB slice).
package img_pkg;

  localparam int IMG_ROW_W    = 512;
  localparam int IMG_ROWS_MAX = 512;
  localparam int IMG_ADDR_W   = 9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } img_pack_state_t;

  // Lowest bit index of word slot k in a packed row of w-bit words.
  function automatic int unsigned slot_lo(input int unsigned k, input int unsigned w);
`ifdef IMG_PACK_MSB_FIRST_EN
    return IMG_ROW_W - (k + 1) * w;
`else
    return k * w;
`endif
  endfunction

endpackage

// File: rtl/img_row_packer_if.sv
// Pixel stream (valid/ready) plus row-buffer write port of the row packer.
// A word transfers on a posedge where in_valid and in_ready are both 1; in_data holds while in_valid waits.
interface img_row_packer_if
  import img_pkg::*;
#(
  parameter int IN_W = 32
);
  logic                  in_valid;
  logic [IN_W-1:0]       in_data;
  logic                  in_ready;
  logic                  we;
  logic [IMG_ADDR_W-1:0] waddr;
  logic [IMG_ROW_W-1:0]  wdata;

  modport master (output in_valid, in_data, input in_ready, we, waddr, wdata);
  modport slave  (input in_valid, in_data, output in_ready, we, waddr, wdata);
endinterface

// File: rtl/img_row_packer.sv
// Packs IN_W-bit pixel words into 512-bit rows and writes ROWS rows per frame.
// IMG_PACK_MSB_FIRST_EN selects MSB-first slot order; timing is the same in both builds.
module img_row_packer
  import img_pkg::*;
#(
  parameter int IN_W = 32,
  parameter int ROWS = 512
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  img_row_packer_if.slave  bus,
  output logic             busy,
  output logic             frame_done,
  output img_pack_state_t  state_dbg_o
);

  localparam int WPR   = IMG_ROW_W / IN_W;
  localparam int WC_W  = (WPR > 1) ? $clog2(WPR) : 1;
  localparam int IDX_W = $clog2(IMG_ROW_W);

  img_pack_state_t       state_q;
  logic [IMG_ROW_W-1:0]  row_q;
  logic [WC_W-1:0]       word_q;
  logic [IMG_ADDR_W-1:0] row_cnt_q;
  logic [IMG_ADDR_W-1:0] waddr_q;
  logic                  we_q;
  logic                  in_ready_q;
  logic                  busy_q;
  logic                  done_q;
  logic [IDX_W-1:0]      slot_lo_w;

  assign slot_lo_w = IDX_W'(slot_lo(32'(word_q), IN_W));

  // Outputs are registered: each transition also loads the flags of the state it enters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      row_q      <= '0;
      word_q     <= '0;
      row_cnt_q  <= '0;
      waddr_q    <= '0;
      we_q       <= 1'b0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      we_q   <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            word_q     <= '0;
            row_cnt_q  <= '0;
            state_q    <= FILL;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        FILL: begin
          if (bus.in_valid && in_ready_q) begin
            row_q[slot_lo_w +: IN_W] <= bus.in_data;
            if (word_q == WC_W'(WPR - 1)) begin
              word_q     <= '0;
              state_q    <= WRITE;
              in_ready_q <= 1'b0;
              we_q       <= 1'b1;
              waddr_q    <= row_cnt_q;
            end else begin
              word_q <= word_q + 1'b1;
            end
          end
        end
        WRITE: begin
          // The row counter saturates on the last row instead of wrapping.
          if (row_cnt_q == IMG_ADDR_W'(ROWS - 1)) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else begin
            row_cnt_q  <= row_cnt_q + 1'b1;
            word_q     <= '0;
            state_q    <= FILL;
            in_ready_q <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q    <= IDLE;
          in_ready_q <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready = in_ready_q;
  assign bus.we       = we_q;
  assign bus.waddr    = waddr_q;
  assign bus.wdata    = row_q;
  assign busy         = busy_q;
  assign frame_done   = done_q;
  assign state_dbg_o  = state_q;

endmodule

// File: doc/img_row_packer.md
IMG_ROW_PACKER -- requirements
Module: img_row_packer

Interface
REQ-001 Parameter IN_W, default 32, input word width in bits; SHALL divide 512 evenly.
REQ-002 Parameter ROWS, default 512, rows per frame; SHALL be at most 512.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 start  input  1  one-cycle pulse that begins frame capture.
REQ-006 in_valid  input  1  in_data is valid this cycle.
REQ-007 in_data  input  IN_W  pixel word from the upstream source.
REQ-008 in_ready  output  1  block accepts in_data this cycle.
REQ-009 we  output  1  row write strobe to the image buffer.
REQ-010 waddr  output  9  row address for the image buffer.
REQ-011 wdata  output  512  packed row for the image buffer.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 frame_done  output  1  one-cycle pulse after the last row is written.

Function
REQ-014 The state machine SHALL have four states: IDLE, FILL, WRITE and DONE.
REQ-015 In IDLE, start=1 SHALL clear the row and word counters and move to FILL on the next edge.
REQ-016 start SHALL be ignored in FILL, WRITE and DONE.
REQ-017 in_ready SHALL be 1 only in FILL; a word is accepted when in_valid and in_ready are both 1 on an edge.
REQ-018 In FILL, each accepted word SHALL go into word slot k of the row register; k counts 0 to WPR-1, where WPR = 512/IN_W.
REQ-019 The WPR-th accepted word SHALL move the state to WRITE; if in_valid=0, FILL SHALL hold with no change.
REQ-020 In WRITE, we SHALL be 1 for exactly one cycle; waddr SHALL equal the row counter and wdata the completed row register.
REQ-021 In all other states we SHALL be 0, waddr SHALL hold the last row written, and wdata SHALL hold the row register.
REQ-022 Leaving WRITE, the row counter SHALL increment; if it was ROWS-1 the next state is DONE, otherwise FILL with the word counter at 0.
REQ-023 DONE SHALL assert frame_done for one cycle, then go to IDLE; the row counter SHALL not wrap past ROWS-1.
REQ-024 The first row write SHALL occur on the cycle after the edge that accepts the WPR-th word.
REQ-025 Minimum frame time SHALL be ROWS*(WPR+1)+2 cycles after start.

Reset
REQ-026 rst=1 SHALL force IDLE and clear all counters and the row register.
REQ-027 Output values during and after reset: in_ready=0, we=0, waddr=0, wdata=0, busy=0, frame_done=0.
REQ-028 Reset SHALL take priority over start and in_valid on the same edge.
REQ-029 Reset mid-frame SHALL abort the frame with no further we and no frame_done; partial rows are discarded.

Configuration
REQ-030 Macro IMG_PACK_MSB_FIRST_EN selects the slot order.
- Defined: word k SHALL be placed at wdata[511-k*IN_W -: IN_W], so the first word is the MSB slice.
- Undefined: word k SHALL be placed at wdata[k*IN_W +: IN_W], so the first word is the LSB slice.
- All timing SHALL be identical in both builds.

Structure
REQ-031 The shared package img_pkg SHALL define IMG_ROW_W=512, IMG_ROWS_MAX=512, IMG_ADDR_W=9 and the state enum img_pack_state_t.
REQ-032 The block SHALL be a single module with no sub-modules; waddr/wdata SHALL connect directly to the 512x512 row image buffer write port.

Verification
REQ-033 Reset, then start, then 16 words 0x00000001..0x00000010 with in_valid held high (IN_W=32, LSB-first build) -> we=1 on the following cycle, waddr=0, wdata[31:0]=0x1, wdata[511:480]=0x10.
REQ-034 Same stimulus in the IMG_PACK_MSB_FIRST_EN build -> wdata[511:480]=0x1 and wdata[31:0]=0x10.
REQ-035 in_valid toggling 1,0,1,0 across a row -> exactly 16 accepts, one we pulse, and no words lost or duplicated.
REQ-036 Full frame with ROWS=4 -> we pulses at waddr 0,1,2,3; frame_done fires once, 1 cycle after the last WRITE; busy=0 after that; a start during the frame is ignored.
REQ-037 rst asserted after 8 words of row 2 -> next cycle in_ready=0 and busy=0; no we; a new start writes from waddr=0 again.
REQ-038 start and rst asserted on the same edge -> block stays in IDLE with busy=0.
